// File: rtl/eeprom_backup.sv
// EEPROM save-image backup: an 8 KiB dual-port RAM shared by the EEPROM core and an SD host.
// The image is loaded when it is mounted, filled with 0xFF when the image is empty, and written back on request.
module eeprom_backup #(
  parameter logic [31:0] LBA_BASE = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] ram_addr,
  input  logic [7:0]  ram_d,
  input  logic        ram_wr,
  input  logic        ram_rd,
  output logic [7:0]  ram_q,
  input  logic [12:0] mask,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [31:0] img_size,
  input  logic        bk_save,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        busy,
  output logic        dirty
);

  // state     | meaning
  // IDLE      | waiting for a mount or a pending save
  // ERASE     | filling the whole RAM with 0xFF
  // LOAD_REQ  | sd_rd raised for sector cnt, waiting for ack
  // LOAD_XFER | host writing sector cnt into RAM
  // SAVE_REQ  | sd_wr raised for sector cnt, waiting for ack
  // SAVE_XFER | host reading sector cnt out of RAM
  typedef enum logic [2:0] {
    IDLE, ERASE, LOAD_REQ, LOAD_XFER, SAVE_REQ, SAVE_XFER
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [12:0] ecnt_q, ecnt_d;
  logic        dirty_q, dirty_d;
  logic        pend_q, pend_d;
  logic        ack_q;
  logic [7:0]  ram_q_q;
  logic [7:0]  din_q;
  logic        dirty_clr;
  logic        pend_clr;

  logic [7:0]  mem [0:8191];

  logic [13:0] size_w;
  logic [4:0]  nsect_raw;
  logic [4:0]  nsect_m1;
  logic [3:0]  last_sect;
  logic        ack_rise, ack_fall;
  logic        port_a_we;
  logic        port_b_we;
  logic [12:0] port_b_addr;
  logic [7:0]  port_b_wd;

  // Images smaller than one sector still occupy a full sector on the card.
  assign size_w    = {1'b0, mask} + 14'd1;
  assign nsect_raw = size_w[13:9];
  assign nsect_m1  = (nsect_raw == 5'd0) ? 5'd0 : nsect_raw - 5'd1;
  assign last_sect = nsect_m1[3:0];

  assign ack_rise  = sd_ack & ~ack_q;
  assign ack_fall  = ~sd_ack & ack_q;

  assign port_a_we   = ram_wr && !(state_q inside {ERASE, LOAD_REQ, LOAD_XFER});
  assign port_b_we   = (state_q == ERASE) || ((state_q == LOAD_XFER) && sd_buff_wr);
  assign port_b_addr = (state_q == ERASE) ? ecnt_q : {cnt_q, sd_buff_addr};
  assign port_b_wd   = (state_q == ERASE) ? 8'hFF : sd_buff_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ecnt_q  <= '0;
      dirty_q <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ecnt_q  <= ecnt_d;
      dirty_q <= dirty_d;
      pend_q  <= pend_d;
      ack_q   <= sd_ack;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ecnt_d    = ecnt_q;
    dirty_clr = 1'b0;
    pend_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (img_mounted) begin
          if (img_size != 32'd0) begin
            state_d   = LOAD_REQ;
            cnt_d     = '0;
            dirty_clr = 1'b1;
          end else begin
            state_d = ERASE;
            ecnt_d  = '0;
          end
        end else if (pend_q) begin
          pend_clr = 1'b1;
          if (dirty_q && !img_readonly && (img_size != 32'd0)) begin
            state_d   = SAVE_REQ;
            cnt_d     = '0;
            dirty_clr = 1'b1;
          end
        end
      end
      ERASE: begin
        ecnt_d = ecnt_q + 13'd1;
        if (ecnt_q == 13'h1FFF) begin
          state_d   = IDLE;
          dirty_clr = 1'b1;
        end
      end
      LOAD_REQ:  if (ack_rise) state_d = LOAD_XFER;
      LOAD_XFER: begin
        if (ack_fall) begin
          if (cnt_q == last_sect) state_d = IDLE;
          else begin
            cnt_d   = cnt_q + 4'd1;
            state_d = LOAD_REQ;
          end
        end
      end
      SAVE_REQ:  if (ack_rise) state_d = SAVE_XFER;
      SAVE_XFER: begin
        if (ack_fall) begin
          if (cnt_q == last_sect) state_d = IDLE;
          else begin
            cnt_d   = cnt_q + 4'd1;
            state_d = SAVE_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh request in the same cycle as a consumed one must survive.
    pend_d  = (pend_q & ~pend_clr) | bk_save;
    dirty_d = port_a_we ? 1'b1 : (dirty_q & ~dirty_clr);
  end

  always_comb begin
    busy   = (state_q != IDLE);
    sd_rd  = (state_q == LOAD_REQ);
    sd_wr  = (state_q == SAVE_REQ);
    sd_lba = 32'd0;
    if (state_q inside {LOAD_REQ, LOAD_XFER, SAVE_REQ, SAVE_XFER})
      sd_lba = LBA_BASE + {28'd0, cnt_q};
  end

  always_ff @(posedge clk) begin
    if (port_a_we) mem[ram_addr] <= ram_d;
    if (port_b_we) mem[port_b_addr] <= port_b_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_q_q <= 8'd0;
      din_q   <= 8'd0;
    end else begin
      if (ram_rd) ram_q_q <= mem[ram_addr];
      din_q <= mem[port_b_addr];
    end
  end

  assign ram_q       = ram_q_q;
  assign sd_buff_din = din_q;
  assign dirty       = dirty_q;

endmodule

// File: tb/tb_eeprom_backup.sv
// Bench for eeprom_backup: an SD host model plus a byte-array image of the RAM contents.
module tb_eeprom_backup;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] ram_addr;
  logic [7:0]  ram_d;
  logic        ram_wr, ram_rd;
  logic [7:0]  ram_q;
  logic [12:0] mask;
  logic        img_mounted, img_readonly;
  logic [31:0] img_size;
  logic        bk_save;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic        busy, dirty;

  eeprom_backup dut (
    .clk(clk), .rst_n(rst_n),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_q(ram_q),
    .mask(mask), .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .bk_save(bk_save), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .busy(busy), .dirty(dirty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [0:8191];
  logic [7:0] snap    [0:8191];
  logic [7:0] sbuf    [0:511];

  function automatic int nsect(input int m);
    int n;
    n = (m + 1) / 512;
    return (n == 0) ? 1 : n;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [12:0] a, input logic [7:0] d);
    ram_addr = a; ram_d = d; ram_wr = 1'b1;
    @(negedge clk);
    ram_wr = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic rd(input logic [12:0] a, output logic [7:0] d);
    ram_addr = a; ram_rd = 1'b1;
    @(negedge clk);
    ram_rd = 1'b0;
    d = ram_q;
  endtask

  task automatic pulse_save();
    bk_save = 1'b1;
    @(negedge clk);
    bk_save = 1'b0;
  endtask

  task automatic pulse_mount();
    img_mounted = 1'b1;
    @(negedge clk);
    img_mounted = 1'b0;
  endtask

  task automatic wait_req(input int budget, output bit got);
    got = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (sd_rd === 1'b1 || sd_wr === 1'b1) begin
        got = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_ack(input logic lvl, output bit got);
    got = 1'b0;
    for (int n = 0; n < 30000; n++) begin
      if (sd_ack === lvl) begin
        got = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_no_req(input string name, input int budget);
    bit got;
    wait_req(budget, got);
    checks++;
    if (got) begin
      failures++;
      $display("FAIL %s got rd=%0b wr=%0b lba=%0d exp no request", name, sd_rd, sd_wr, sd_lba);
    end
  endtask

  // One host handshake: waits for the request, checks it, then moves a whole sector.
  task automatic serve(input bit exp_write, input logic [31:0] exp_lba);
    bit got;
    logic [12:0] a;
    wait_req(20000, got);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL req_timeout got none exp %s lba=%0d", exp_write ? "wr" : "rd", exp_lba);
      return;
    end
    checks++;
    if ({sd_wr, sd_rd} !== (exp_write ? 2'b10 : 2'b01)) begin
      failures++;
      $display("FAIL req_dir got wr=%0b rd=%0b exp wr=%0b rd=%0b", sd_wr, sd_rd, exp_write, !exp_write);
    end
    checks++;
    if (sd_lba !== exp_lba) begin
      failures++;
      $display("FAIL req_lba got=%0d exp=%0d", sd_lba, exp_lba);
    end
    sd_ack = 1'b1;
    @(negedge clk);
    checks++;
    if ((sd_rd | sd_wr) !== 1'b0) begin
      failures++;
      $display("FAIL req_drop got rd=%0b wr=%0b exp 0", sd_rd, sd_wr);
    end
    for (int i = 0; i < 512; i++) begin
      sd_buff_addr = 9'(i);
      if (!exp_write) begin
        sd_buff_dout = 8'(i) ^ exp_lba[7:0];
        sd_buff_wr   = 1'b1;
        a = {exp_lba[3:0], 9'(i)};
        ref_mem[a] = 8'(i) ^ exp_lba[7:0];
        @(negedge clk);
      end else begin
        @(negedge clk);
        sbuf[i] = sd_buff_din;
      end
    end
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic compare_sbuf(input string name, input bit use_snap);
    int errs;
    int first;
    logic [7:0] e;
    errs = 0; first = -1;
    for (int i = 0; i < 512; i++) begin
      e = use_snap ? snap[i] : ref_mem[i];
      if (sbuf[i] !== e) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (errs != 0) begin
      failures++;
      e = use_snap ? snap[first] : ref_mem[first];
      $display("FAIL %s bytes_wrong=%0d first idx=%0h got=%0h exp=%0h", name, errs, first, sbuf[first], e);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b", name, got, exp);
    end
  endtask

  task automatic check_rd(input string name, input logic [12:0] a);
    logic [7:0] d;
    rd(a, d);
    checks++;
    if (d !== ref_mem[a]) begin
      failures++;
      $display("FAIL %s addr=%0h got=%0h exp=%0h", name, a, d, ref_mem[a]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_dirty", dirty, 1'b0);
    check_bit("rst_sd_rd", sd_rd, 1'b0);
    check_bit("rst_sd_wr", sd_wr, 1'b0);
    checks++;
    if (sd_lba !== 32'd0 || ram_q !== 8'd0 || sd_buff_din !== 8'd0) begin
      failures++;
      $display("FAIL rst_data got lba=%0h q=%0h din=%0h exp 0 0 0", sd_lba, ram_q, sd_buff_din);
    end
    rst_n = 1'b1;
    tick(2);
    check_bit("post_rst_busy", busy, 1'b0);
  endtask

  task automatic test_load_full();
    logic [7:0] d0, d1;
    mask = 13'd8191; img_size = 32'd8192; img_readonly = 1'b0;
    pulse_mount();
    check_bit("load_busy", busy, 1'b1);
    for (int s = 0; s < nsect(8191); s++) serve(1'b0, 32'(s));
    check_bit("load_busy_end", busy, 1'b0);
    check_bit("load_dirty", dirty, 1'b0);
    checks++;
    if (ref_mem[13'h1203] !== 8'h0A) begin
      failures++;
      $display("FAIL load_model got=%0h exp=0a", ref_mem[13'h1203]);
    end
    check_rd("load_1203", 13'h1203);
    for (int k = 0; k < 6; k++) check_rd("load_rand", 13'($urandom_range(0, 8191)));
    rd(13'h0777, d0);
    tick(3);
    d1 = ram_q;
    checks++;
    if (d1 !== d0) begin
      failures++;
      $display("FAIL ram_q_hold got=%0h exp=%0h", d1, d0);
    end
    expect_no_req("load_no_extra", 50);
  endtask

  task automatic test_erase();
    int n;
    img_size = 32'd0;
    pulse_mount();
    n = 0;
    while (busy === 1'b1 && n < 10000) begin
      n++;
      if (n == 100) img_size = 32'd8192;
      img_mounted = (n == 100);
      @(negedge clk);
    end
    img_mounted = 1'b0;
    img_size = 32'd0;
    checks++;
    if (n != 8192) begin
      failures++;
      $display("FAIL erase_cycles got=%0d exp=8192", n);
    end
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'hFF;
    check_bit("erase_dirty", dirty, 1'b0);
    expect_no_req("erase_mount_ignored", 50);
    check_rd("erase_0055", 13'h0055);
    for (int k = 0; k < 4; k++) check_rd("erase_rand", 13'($urandom_range(0, 8191)));
  endtask

  task automatic test_write_save();
    mask = 13'd127; img_size = 32'd128; img_readonly = 1'b0;
    wr(13'h0010, 8'hA5);
    for (int k = 0; k < 6; k++) wr(13'($urandom_range(17, 127)), 8'($urandom));
    check_bit("ws_dirty_set", dirty, 1'b1);
    pulse_save();
    serve(1'b1, 32'd0);
    check_bit("ws_busy_end", busy, 1'b0);
    check_bit("ws_dirty_clr", dirty, 1'b0);
    checks++;
    if (sbuf[16] !== 8'hA5) begin
      failures++;
      $display("FAIL ws_byte10 got=%0h exp=a5", sbuf[16]);
    end
    compare_sbuf("ws_sector", 1'b0);
    expect_no_req("ws_single", 100);
  endtask

  task automatic test_save_during_save();
    bit got;
    wr(13'h0020, 8'($urandom));
    for (int i = 0; i < 8192; i++) snap[i] = ref_mem[i];
    pulse_save();
    fork
      serve(1'b1, 32'd0);
      begin
        wait_ack(1'b1, got);
        tick(300);
        wr(13'h0005, ~snap[5]);
        tick(2);
        check_bit("sds_dirty_reset", dirty, 1'b1);
        check_bit("sds_busy", busy, 1'b1);
        for (int k = 0; k < 3; k++) begin
          pulse_save();
          tick(5);
        end
      end
    join
    compare_sbuf("sds_first", 1'b1);
    serve(1'b1, 32'd0);
    compare_sbuf("sds_second", 1'b0);
    check_bit("sds_dirty_end", dirty, 1'b0);
    expect_no_req("sds_coalesced", 100);
  endtask

  task automatic test_load_ignores();
    bit got;
    logic [7:0] junk;
    mask = 13'd2047; img_size = 32'd2048;
    wr(13'h0100, 8'h11);
    pulse_mount();
    fork
      for (int s = 0; s < nsect(2047); s++) serve(1'b0, 32'(s));
      begin
        wait_ack(1'b1, got);
        for (int k = 0; k < 3; k++) begin
          pulse_save();
          tick(10);
        end
        wait_ack(1'b0, got);
        wait_ack(1'b1, got);
        wait_ack(1'b0, got);
        wait_ack(1'b1, got);
        tick(5);
        junk = ~ref_mem[5];
        ram_addr = 13'h0005; ram_d = junk; ram_wr = 1'b1;
        @(negedge clk);
        ram_wr = 1'b0;
      end
    join
    check_bit("li_busy_end", busy, 1'b0);
    check_bit("li_dirty", dirty, 1'b0);
    check_rd("li_write_ignored", 13'h0005);
    expect_no_req("li_save_dropped", 100);
  endtask

  task automatic test_save_dropped();
    mask = 13'd127; img_size = 32'd128;
    wr(13'($urandom_range(0, 127)), 8'($urandom));
    img_readonly = 1'b1;
    pulse_save();
    expect_no_req("ro_no_save", 100);
    check_bit("ro_dirty_kept", dirty, 1'b1);
    img_readonly = 1'b0;
    expect_no_req("ro_pend_cleared", 50);
    img_mounted = 1'b1; bk_save = 1'b1;
    @(negedge clk);
    img_mounted = 1'b0; bk_save = 1'b0;
    serve(1'b0, 32'd0);
    check_bit("ms_dirty", dirty, 1'b0);
    expect_no_req("ms_clean_save_dropped", 100);
  endtask

  task automatic test_reset_mid_save();
    bit got;
    wr(13'h0030, 8'($urandom));
    pulse_save();
    wait_req(200, got);
    check_bit("rms_req", sd_wr, 1'b1);
    sd_ack = 1'b1;
    tick(3);
    sd_buff_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sd_buff_addr = 9'(i);
      sd_buff_dout = 8'h3C ^ 8'(i);
      if (i == 2) begin
        #2 rst_n = 1'b0;
        #1;
        check_bit("rms_sd_wr", sd_wr, 1'b0);
        check_bit("rms_busy", busy, 1'b0);
        check_bit("rms_dirty", dirty, 1'b0);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int i = 6; i < 10; i++) begin
      sd_buff_addr = 9'(i);
      sd_buff_dout = 8'h3C ^ 8'(i);
      @(negedge clk);
    end
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    tick(2);
    for (int i = 0; i < 10; i++) check_rd("rms_no_ram_write", 13'(i));
    expect_no_req("rms_no_req", 50);
  endtask

  initial begin
    rst_n = 1'b0;
    ram_addr = '0; ram_d = '0; ram_wr = 1'b0; ram_rd = 1'b0;
    mask = 13'd127; img_mounted = 1'b0; img_readonly = 1'b0; img_size = 32'd0;
    bk_save = 1'b0; sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_load_full();
    test_erase();
    test_write_save();
    test_save_during_save();
    test_load_ignores();
    test_save_dropped();
    test_reset_mid_save();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eeprom_backup.md
EEPROM_BACKUP -- requirements
Module: eeprom_backup

Interface
REQ-001 SHALL have parameter LBA_BASE, default 0, meaning the first SD sector of the save image.
REQ-002 SHALL have clk  in  1  system clock, all logic on its rising edge.
REQ-003 SHALL have rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ram_addr  in  13  EEPROM-core byte address, already masked.
REQ-005 SHALL have ram_d  in  8  EEPROM-core write data.
REQ-006 SHALL have ram_wr  in  1  EEPROM-core write strobe, one cycle.
REQ-007 SHALL have ram_rd  in  1  EEPROM-core read strobe, one cycle.
REQ-008 SHALL have ram_q  out  8  EEPROM-core read data.
REQ-009 SHALL have mask  in  13  active EEPROM size minus 1 (127, 255, 2047 or 8191).
REQ-010 SHALL have img_mounted  in  1  one-cycle pulse when the save image is mounted.
REQ-011 SHALL have img_readonly  in  1  image is read-only.
REQ-012 SHALL have img_size  in  32  image size in bytes.
REQ-013 SHALL have bk_save  in  1  one-cycle save request.
REQ-014 SHALL have sd_lba  out  32  sector number.
REQ-015 SHALL have sd_rd  out  1  sector read request.
REQ-016 SHALL have sd_wr  out  1  sector write request.
REQ-017 SHALL have sd_ack  in  1  host transfer-active acknowledge.
REQ-018 SHALL have sd_buff_addr  in  9  byte index within the sector.
REQ-019 SHALL have sd_buff_dout  in  8  host-to-block data.
REQ-020 SHALL have sd_buff_wr  in  1  host-to-block write strobe.
REQ-021 SHALL have sd_buff_din  out  8  block-to-host data.
REQ-022 SHALL have busy  out  1  load, erase or save in progress.
REQ-023 SHALL have dirty  out  1  contents modified since the last load or save.

Function
REQ-024 SHALL hold 8192x8 dual-port RAM: port A serves the EEPROM core, port B serves the SD side or the erase counter.
REQ-025 Port A SHALL register ram_q 1 cycle after ram_rd from ram_addr, holding the value until the next ram_rd.
REQ-026 ram_wr SHALL write ram_d at ram_addr and set dirty the next cycle, except in LOAD or ERASE, where it is ignored.
REQ-027 nsect SHALL be max(1, (mask+1)>>9): 1 for mask 127/255, 4 for 2047, 16 for 8191.
REQ-028 FSM states SHALL be IDLE, ERASE, LOAD_REQ, LOAD_XFER, SAVE_REQ, SAVE_XFER.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 IDLE + img_mounted, img_size!=0 -> LOAD_REQ with sector counter 0 and dirty cleared.
REQ-031 IDLE + img_mounted, img_size==0 -> ERASE.
REQ-032 ERASE SHALL write 0xFF to addresses 0..8191, one per cycle, with a 13-bit counter, then go to IDLE with dirty=0 (8192 cycles).
REQ-033 LOAD_REQ SHALL drive sd_lba=LBA_BASE+cnt and sd_rd=1, and on the sd_ack rise drop sd_rd and go to LOAD_XFER.
REQ-034 In LOAD_XFER, each sd_buff_wr SHALL write sd_buff_dout to RAM[{cnt[3:0],sd_buff_addr}] (address truncated to 13 bits).
REQ-035 On the sd_ack fall in LOAD_XFER: if cnt==nsect-1 go to IDLE, else increment cnt and go to LOAD_REQ.
REQ-036 IDLE + save pending, dirty=1, img_readonly=0, img_size!=0 -> SAVE_REQ, clear dirty, cnt=0.
REQ-037 A save pending with no effect under REQ-036 SHALL be dropped.
REQ-038 SAVE_REQ/SAVE_XFER SHALL mirror REQ-033/035 using sd_wr.
REQ-039 In SAVE_XFER, sd_buff_din SHALL be RAM[{cnt[3:0],sd_buff_addr}], registered with 1-cycle latency.
REQ-040 bk_save arriving while busy SHALL set a pending flag, serviced on return to IDLE; repeated requests SHALL coalesce into one.
REQ-041 ram_wr during a save SHALL re-set dirty; it does not abort the save.
REQ-042 img_mounted and bk_save in the same cycle: the mount SHALL be serviced first and the save stays pending.
REQ-043 img_mounted while busy SHALL be ignored.
REQ-044 sd_rd and sd_wr SHALL never be 1 simultaneously.
REQ-045 sd_lba SHALL be 0 in IDLE.

Reset
REQ-046 rst_n=0 SHALL force asynchronously: state=IDLE, busy=0, dirty=0, pending=0, cnt=0, sd_rd=0, sd_wr=0, sd_lba=0, ram_q=0, sd_buff_din=0.
REQ-047 RAM contents SHALL NOT be reset.
REQ-048 Reset mid-transfer SHALL drop the request immediately with no further RAM writes.

Verification
REQ-049 Mount, size 8192, mask 8191, host model supplies byte = addr^lba -> 16 sd_rd handshakes on lba 0..15, RAM[0x1203]=0x03^0x09=0x0A, busy falls after the last ack, dirty=0.
REQ-050 Mount, size 0 -> busy high for 8192 cycles, then ram_rd at 0x0055 returns 0xFF one cycle later.
REQ-051 ram_wr 0xA5@0x0010 then bk_save, mask 127 -> dirty=1, one sd_wr at lba 0, host reads 0xA5 at index 0x10, dirty=0 after the handshake.
REQ-052 bk_save x3 during a load -> exactly one save after the load ends, and only if dirty.
REQ-053 bk_save with img_readonly=1, or with dirty=0 -> no sd_wr, pending cleared.
REQ-054 rst_n low during SAVE_XFER -> sd_wr=0, busy=0, dirty=0 in the same cycle, with no RAM writes.
